// File: rtl/seg_frame_decoder_if.sv
// ----------------------------------------------------------------------------
// seg_frame_decoder_if
// Snooped seven-segment display bus. The board driver is the master: it
// drives the multiplexed active-low segment lines and the active-low digit
// enables. The frame decoder only ever observes the bus, so it connects
// through the slave modport.
//
// Signals:
//   segs     [7:0]            active-low segments, bit7 = DP, bits6:0 = g..a
//   dig_sel  [NUM_DIGITS-1:0] active-low digit enables, one low bit per digit
// ----------------------------------------------------------------------------
interface seg_frame_decoder_if #(
   parameter int NUM_DIGITS = 6
);
   logic [7:0]            segs;
   logic [NUM_DIGITS-1:0] dig_sel;

   // Driver side of the display bus
   modport master (
      output segs,
      output dig_sel
   );

   // Observer side of the display bus
   modport slave (
      input segs,
      input dig_sel
   );
endinterface

// File: rtl/seg_frame_decoder.sv
// ----------------------------------------------------------------------------
// seg_frame_decoder
// Watches a multiplexed seven-segment display bus and rebuilds the BCD value
// being shown on every digit. A digit is only accepted once the same
// {dig_sel, segs} sample has been held for STABLE_CYCLES consecutive cycles,
// which rejects scan transitions and glitches. Blank (all segments off) and
// undecodable patterns are flagged per digit. A one-cycle strobe marks each
// point where every digit has been captured since the previous strobe.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   bus            snooped display bus (slave modport): segs, dig_sel
//   digits_o       decoded nibble per digit, digit i at [4i+3:4i]
//   blank_o        digit i last committed as all-off
//   invalid_o      digit i last committed as an undecodable pattern
//   frame_valid_o  one-cycle pulse once all digits have been committed
//   sel_err_o      sticky flag, a multi-hot dig_sel was observed
//   bad_count_o    saturating count of undecodable commits
// ----------------------------------------------------------------------------
module seg_frame_decoder #(
   parameter int NUM_DIGITS    = 6,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   seg_frame_decoder_if.slave      bus,
   output logic [4*NUM_DIGITS-1:0] digits_o,
   output logic [NUM_DIGITS-1:0]   blank_o,
   output logic [NUM_DIGITS-1:0]   invalid_o,
   output logic                    frame_valid_o,
   output logic                    sel_err_o,
   output logic [7:0]              bad_count_o
);

   localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SAMPLE_W = NUM_DIGITS + 8;
   localparam logic [4:0] STABLE_MAX = 5'(STABLE_CYCLES);

   typedef struct packed {
      logic       blank;
      logic       invalid;
      logic [3:0] value;
   } decodeT;

   // Full 8-bit compare, including DP. Anything not in the table is reported
   // as undecodable so that a damaged pattern can never pass as a real digit.
   function automatic decodeT decodeSegs(input logic [7:0] pattern);
      decodeT result;
      result = '{blank: 1'b0, invalid: 1'b0, value: 4'h0};
      case (pattern)
         8'hC0:   result.value = 4'd0;
         8'hF9:   result.value = 4'd1;
         8'hA4:   result.value = 4'd2;
         8'hB0:   result.value = 4'd3;
         8'h99:   result.value = 4'd4;
         8'h92:   result.value = 4'd5;
         8'h82:   result.value = 4'd6;
         8'hF8:   result.value = 4'd7;
         8'h80:   result.value = 4'd8;
         8'h90:   result.value = 4'd9;
         8'hFF: begin
            result.blank = 1'b1;
            result.value = 4'hF;
         end
         default: begin
            result.invalid = 1'b1;
            result.value   = 4'hE;
         end
      endcase
      return result;
   endfunction

   // Registered state
   logic [4*NUM_DIGITS-1:0] digits_q,     digits_d;
   logic [NUM_DIGITS-1:0]   blank_q,      blank_d;
   logic [NUM_DIGITS-1:0]   invalid_q,    invalid_d;
   logic                    frameValid_q, frameValid_d;
   logic                    selErr_q,     selErr_d;
   logic [7:0]              badCount_q,   badCount_d;
   logic [4:0]              cnt_q,        cnt_d;
   logic                    committed_q,  committed_d;
   logic [SAMPLE_W-1:0]     prevSample_q, prevSample_d;
   logic                    prevValid_q,  prevValid_d;
   logic [NUM_DIGITS-1:0]   frameMask_q,  frameMask_d;

   // Select qualification
   logic [3:0]            lowCount;
   logic [IDX_W-1:0]      selIdx;
   logic                  sampleValid;
   logic                  multiHot;
   logic [SAMPLE_W-1:0]   curSample;
   logic                  sameSample;
   logic                  commit;
   decodeT                decoded;
   logic [NUM_DIGITS-1:0] commitMask;
   logic [NUM_DIGITS-1:0] mergedMask;

   // Count the low enables and remember which one was low. A single low bit
   // is a real sample; none is idle and more than one is a bus fault.
   always_comb begin
      lowCount = 4'd0;
      selIdx   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!bus.dig_sel[i]) begin
            lowCount = lowCount + 4'd1;
            selIdx   = IDX_W'(i);
         end
      end
      sampleValid = (lowCount == 4'd1);
      multiHot    = (lowCount > 4'd1);
   end

   // Stability tracking and commit decision. The run counter saturates at
   // STABLE_CYCLES and the committed flag makes a long hold commit only once;
   // any change of sample, or a break in valid samples, starts a new run.
   always_comb begin
      curSample    = {bus.dig_sel, bus.segs};
      sameSample   = prevValid_q && (curSample == prevSample_q);
      cnt_d        = cnt_q;
      committed_d  = committed_q;
      commit       = 1'b0;
      prevSample_d = curSample;
      prevValid_d  = sampleValid;

      if (!sampleValid) begin
         cnt_d = 5'd0;
      end else if (sameSample) begin
         cnt_d = (cnt_q >= STABLE_MAX) ? STABLE_MAX : cnt_q + 5'd1;
      end else begin
         cnt_d       = 5'd1;
         committed_d = 1'b0;
      end

      if (sampleValid && (cnt_d == STABLE_MAX) && !committed_d) begin
         commit      = 1'b1;
         committed_d = 1'b1;
      end
   end

   // Output update and frame assembly. The commit bit is merged into the
   // mask before testing for completion, so the final digit of a frame
   // raises the strobe on the same edge it lands and the mask restarts empty;
   // a commit during the strobe cycle then simply starts the next frame.
   always_comb begin
      decoded      = decodeSegs(bus.segs);
      digits_d     = digits_q;
      blank_d      = blank_q;
      invalid_d    = invalid_q;
      badCount_d   = badCount_q;
      selErr_d     = selErr_q | multiHot;
      commitMask   = '0;

      if (commit) begin
         commitMask                      = NUM_DIGITS'(1) << selIdx;
         digits_d[4*int'(selIdx) +: 4]   = decoded.value;
         blank_d[selIdx]                 = decoded.blank;
         invalid_d[selIdx]               = decoded.invalid;
         if (decoded.invalid && (badCount_q != 8'hFF)) begin
            badCount_d = badCount_q + 8'd1;
         end
      end

      mergedMask   = frameMask_q | commitMask;
      frameValid_d = &mergedMask;
      frameMask_d  = frameValid_d ? '0 : mergedMask;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         digits_q     <= '1;
         blank_q      <= '1;
         invalid_q    <= '0;
         frameValid_q <= 1'b0;
         selErr_q     <= 1'b0;
         badCount_q   <= 8'd0;
         cnt_q        <= 5'd0;
         committed_q  <= 1'b0;
         prevSample_q <= '0;
         prevValid_q  <= 1'b0;
         frameMask_q  <= '0;
      end else begin
         digits_q     <= digits_d;
         blank_q      <= blank_d;
         invalid_q    <= invalid_d;
         frameValid_q <= frameValid_d;
         selErr_q     <= selErr_d;
         badCount_q   <= badCount_d;
         cnt_q        <= cnt_d;
         committed_q  <= committed_d;
         prevSample_q <= prevSample_d;
         prevValid_q  <= prevValid_d;
         frameMask_q  <= frameMask_d;
      end
   end

   assign digits_o      = digits_q;
   assign blank_o       = blank_q;
   assign invalid_o     = invalid_q;
   assign frame_valid_o = frameValid_q;
   assign sel_err_o     = selErr_q;
   assign bad_count_o   = badCount_q;

endmodule

// File: tb/tb_seg_frame_decoder.sv
// ----------------------------------------------------------------------------
// tb_seg_frame_decoder
// Self-checking bench for seg_frame_decoder (6 digits, 4 stable cycles).
// A behavioural model tracks each run of identical valid samples by its
// length: a run commits exactly when it reaches STABLE_CYCLES samples.
// ----------------------------------------------------------------------------
module tb_seg_frame_decoder;

   localparam int ND = 6;
   localparam int SC = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [23:0]   digits;
   logic [5:0]    blank;
   logic [5:0]    invalid;
   logic          frameValid;
   logic          selErr;
   logic [7:0]    badCount;

   int compared = 0;
   int mismatched = 0;
   int fvSeen = 0;

   seg_frame_decoder_if #(.NUM_DIGITS(ND)) bus ();

   seg_frame_decoder #(
      .NUM_DIGITS(ND),
      .STABLE_CYCLES(SC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .digits_o(digits),
      .blank_o(blank),
      .invalid_o(invalid),
      .frame_valid_o(frameValid),
      .sel_err_o(selErr),
      .bad_count_o(badCount)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Behavioural model state
   int          mDigit[ND];
   bit          mBlank[ND];
   bit          mInvalid[ND];
   bit          mSeen[ND];
   int          mBad;
   bit          mSelErr;
   bit          mFv;
   int          runLen;
   bit          havePrev;
   logic [5:0]  prevSel;
   logic [7:0]  prevSeg;
   logic [7:0]  digitPatterns[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   typedef struct {
      logic [7:0] segs;
      logic [3:0] expValue;
      logic       expBlank;
      logic       expInvalid;
   } vecT;

   task automatic modelReset();
      for (int i = 0; i < ND; i++) begin
         mDigit[i] = 15; mBlank[i] = 1; mInvalid[i] = 0; mSeen[i] = 0;
      end
      mBad = 0; mSelErr = 0; mFv = 0; runLen = 0; havePrev = 0;
      prevSel = '1; prevSeg = '1;
   endtask

   // One clock edge of the model, given the inputs sampled at that edge
   task automatic modelStep(input logic [5:0] sel, input logic [7:0] sg, input logic r);
      int zeros;
      int idx;
      int val;
      bit all;
      mFv = 0;
      if (r) begin
         modelReset();
         return;
      end
      zeros = 0; idx = 0;
      for (int i = 0; i < ND; i++) if (!sel[i]) begin zeros++; idx = i; end
      if (zeros != 1) begin
         havePrev = 0; runLen = 0;
         if (zeros > 1) mSelErr = 1;
         return;
      end
      if (havePrev && sel == prevSel && sg == prevSeg) runLen++;
      else runLen = 1;
      havePrev = 1; prevSel = sel; prevSeg = sg;
      if (runLen != SC) return;
      val = -1;
      for (int p = 0; p < 10; p++) if (digitPatterns[p] == sg) val = p;
      if (val >= 0) begin
         mDigit[idx] = val; mBlank[idx] = 0; mInvalid[idx] = 0;
      end else if (sg == 8'hFF) begin
         mDigit[idx] = 15; mBlank[idx] = 1; mInvalid[idx] = 0;
      end else begin
         mDigit[idx] = 14; mBlank[idx] = 0; mInvalid[idx] = 1;
         if (mBad < 255) mBad++;
      end
      mSeen[idx] = 1;
      all = 1;
      for (int i = 0; i < ND; i++) if (!mSeen[i]) all = 0;
      if (all) begin
         mFv = 1;
         for (int i = 0; i < ND; i++) mSeen[i] = 0;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compareModel();
      logic [23:0] eDig;
      logic [5:0]  eBlank;
      logic [5:0]  eInv;
      for (int i = 0; i < ND; i++) begin
         eDig[4*i +: 4] = 4'(mDigit[i]);
         eBlank[i]      = mBlank[i];
         eInv[i]        = mInvalid[i];
      end
      checkOutput("digits", 32'(digits), 32'(eDig));
      checkOutput("blank", 32'(blank), 32'(eBlank));
      checkOutput("invalid", 32'(invalid), 32'(eInv));
      checkOutput("frame_valid", 32'(frameValid), 32'(mFv));
      checkOutput("sel_err", 32'(selErr), 32'(mSelErr));
      checkOutput("bad_count", 32'(badCount), 32'(mBad));
   endtask

   // Drive one input pattern for a number of cycles, checking every cycle
   task automatic applyStimulus(input logic [5:0] sel, input logic [7:0] sg,
                                input logic r, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         bus.dig_sel = sel;
         bus.segs    = sg;
         rst         = r;
         @(posedge clk);
         modelStep(sel, sg, r);
         #1;
         if (frameValid === 1'b1) fvSeen++;
         compareModel();
      end
   endtask

   function automatic logic [5:0] selFor(input int d);
      logic [5:0] one;
      one = 6'd1 << d;
      return ~one;
   endfunction

   vecT vecs[14];
   int  fvBefore;

   initial begin
      vecs[0]  = '{8'hC0, 4'd0, 1'b0, 1'b0};
      vecs[1]  = '{8'hF9, 4'd1, 1'b0, 1'b0};
      vecs[2]  = '{8'hA4, 4'd2, 1'b0, 1'b0};
      vecs[3]  = '{8'hB0, 4'd3, 1'b0, 1'b0};
      vecs[4]  = '{8'h99, 4'd4, 1'b0, 1'b0};
      vecs[5]  = '{8'h92, 4'd5, 1'b0, 1'b0};
      vecs[6]  = '{8'h82, 4'd6, 1'b0, 1'b0};
      vecs[7]  = '{8'hF8, 4'd7, 1'b0, 1'b0};
      vecs[8]  = '{8'h80, 4'd8, 1'b0, 1'b0};
      vecs[9]  = '{8'h90, 4'd9, 1'b0, 1'b0};
      vecs[10] = '{8'hFF, 4'hF, 1'b1, 1'b0};
      vecs[11] = '{8'h7F, 4'hE, 1'b0, 1'b1};
      vecs[12] = '{8'h00, 4'hE, 1'b0, 1'b1};
      vecs[13] = '{8'h40, 4'hE, 1'b0, 1'b1};

      modelReset();
      bus.dig_sel = '1;
      bus.segs    = '1;

      // Reset state
      applyStimulus(6'h3F, 8'hFF, 1'b1, 2);
      checkOutput("reset_digits", 32'(digits), 32'h00FF_FFFF);
      checkOutput("reset_blank", 32'(blank), 32'h3F);
      checkOutput("reset_bad", 32'(badCount), 32'h0);

      // Decode table, each entry committed on a rotating digit
      for (int v = 0; v < 14; v++) begin
         int d;
         d = v % ND;
         applyStimulus(selFor(d), vecs[v].segs, 1'b0, SC + 1);
         checkOutput("table_value", 32'(digits[4*d +: 4]), 32'(vecs[v].expValue));
         checkOutput("table_blank", 32'(blank[d]), 32'(vecs[v].expBlank));
         checkOutput("table_invalid", 32'(invalid[d]), 32'(vecs[v].expInvalid));
      end

      // Single digit: commit latency and a long hold committing once
      applyStimulus(6'h3F, 8'hFF, 1'b1, 1);
      applyStimulus(6'b111110, 8'hA4, 1'b0, SC - 1);
      checkOutput("latency_early", 32'(digits[3:0]), 32'hF);
      applyStimulus(6'b111110, 8'hA4, 1'b0, 1);
      checkOutput("latency_commit", 32'(digits[3:0]), 32'h2);
      checkOutput("latency_blank0", 32'(blank[0]), 32'h0);
      applyStimulus(6'b111110, 8'hA4, 1'b0, 10);
      checkOutput("hold_digits", 32'(digits), 32'h00FF_FFF2);

      // Full frame with exactly one strobe
      applyStimulus(6'h3F, 8'hFF, 1'b1, 1);
      fvBefore = fvSeen;
      for (int d = 0; d < ND; d++) applyStimulus(selFor(d), digitPatterns[d + 1], 1'b0, 6);
      checkOutput("frame_digits", 32'(digits), 32'h0065_4321);
      checkOutput("frame_pulses", 32'(fvSeen - fvBefore), 32'd1);

      // Glitch rejection on digit 2
      applyStimulus(selFor(2), 8'hC0, 1'b0, 3);
      checkOutput("glitch_hold", 32'(digits[11:8]), 32'h3);
      applyStimulus(selFor(2), 8'hF9, 1'b0, 4);
      checkOutput("glitch_digit2", 32'(digits[11:8]), 32'h1);

      // Invalid pattern held long, then blank
      applyStimulus(6'h3F, 8'hFF, 1'b1, 1);
      applyStimulus(selFor(1), 8'h7F, 1'b0, 20);
      checkOutput("inv_value", 32'(digits[7:4]), 32'hE);
      checkOutput("inv_flag", 32'(invalid[1]), 32'h1);
      checkOutput("inv_count", 32'(badCount), 32'h1);
      applyStimulus(selFor(1), 8'hFF, 1'b0, SC);
      checkOutput("blank_flag", 32'(blank[1]), 32'h1);
      checkOutput("blank_inv", 32'(invalid[1]), 32'h0);

      // Multi-hot select: no commit, sticky error until reset
      applyStimulus(6'h3F, 8'hFF, 1'b1, 1);
      applyStimulus(6'b111100, 8'hC0, 1'b0, 5);
      checkOutput("selerr_set", 32'(selErr), 32'h1);
      checkOutput("selerr_nocommit", 32'(digits), 32'h00FF_FFFF);
      applyStimulus(selFor(0), 8'hC0, 1'b0, SC + 2);
      checkOutput("selerr_sticky", 32'(selErr), 32'h1);
      applyStimulus(6'h3F, 8'hFF, 1'b1, 1);
      checkOutput("selerr_clear", 32'(selErr), 32'h0);

      // Reset mid-frame discards partial progress
      fvBefore = fvSeen;
      for (int d = 0; d < 3; d++) applyStimulus(selFor(d), digitPatterns[d], 1'b0, SC);
      applyStimulus(6'h3F, 8'hFF, 1'b1, 1);
      for (int d = 3; d < ND; d++) applyStimulus(selFor(d), digitPatterns[d], 1'b0, SC + 1);
      checkOutput("rst_midframe_pulses", 32'(fvSeen - fvBefore), 32'd0);

      // Randomized bursts against the model
      for (int n = 0; n < 600; n++) begin
         logic [5:0] sel;
         logic [7:0] sg;
         int pick;
         int a;
         int b;
         pick = $urandom_range(0, 19);
         a    = $urandom_range(0, ND - 1);
         if (pick == 0) sel = 6'h3F;
         else if (pick == 1 && n > 400) begin
            b   = (a + 1 + $urandom_range(0, ND - 2)) % ND;
            sel = selFor(a) & selFor(b);
         end else sel = selFor(a);
         pick = $urandom_range(0, 9);
         if (pick < 7) sg = digitPatterns[$urandom_range(0, 9)];
         else if (pick == 7) sg = 8'hFF;
         else sg = 8'($urandom);
         applyStimulus(sel, sg, ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0,
                       $urandom_range(1, 6));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
